iv_count_fifo_primitives: RTL and testbench
===========================================

# iv_count_fifo_primitives

Bundle of the three sequencing primitives used by the integrity verifier:

- a free-running modulo-N turn counter (CountAlarm behaviour);
- a settable and clearable up-counter (Counter behaviour);
- a small first-word-fall-through FIFO with valid/ready handshakes (FIFORAM behaviour).

The three sub-functions share one clock and one reset but are otherwise independent. The verifier uses them for round-robin hash-engine scheduling, bucket progress tracking and per-bucket header buffering.

## Interface

Parameters:

- AlarmThreshold, 2: modulus of the turn counter (≥1).
- CtrWidth, 5: width of the up-counter.
- CtrInitial, 12: value loaded by reset and by CtrSet.
- FifoWidth, 32: FIFO data width.
- FifoDepth, 2: FIFO capacity in entries (≥1; need not be a power of 2).

Ports:

- Clock  in  1  single system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- AlarmEnable  in  1  advance turn counter.
- AlarmCount  out  AW = max(1, clog2(AlarmThreshold))  current turn.
- AlarmDone  out  1  wrap pulse.
- CtrSet  in  1  synchronous load of CtrInitial.
- CtrClear  in  1  synchronous clear to 0.
- CtrLoad  in  1  synchronous load of CtrIn.
- CtrEnable  in  1  increment.
- CtrIn  in  CtrWidth  load value.
- CtrCount  out  CtrWidth  counter value.
- InData  in  FifoWidth  push data.
- InValid  in  1  push request.
- InAccept  out  1  FIFO can take data.
- OutData  out  FifoWidth  head entry.
- OutSend  out  1  head entry is valid.
- OutReady  in  1  consumer pops the head.

## Operation

Turn counter:

- Counts 0, 1, …, AlarmThreshold−1, 0, … on each cycle with AlarmEnable=1; holds otherwise.
- AlarmDone = AlarmEnable && AlarmCount==AlarmThreshold−1 (combinational).
- AlarmThreshold=1: AlarmCount stays 0 and AlarmDone = AlarmEnable.

Up-counter, per-edge priority:

1. CtrSet → CtrInitial.
2. CtrClear → 0.
3. CtrLoad → CtrIn.
4. CtrEnable → +1.
5. Otherwise hold.

Counter arithmetic:

- Increment wraps modulo 2^CtrWidth (all-ones+1 → 0); no saturation.
- CtrIn is ignored unless CtrLoad is the winning action, so X on CtrIn is harmless.

FIFO:

- Storage is a FifoDepth-entry register/RAM array with read pointer, write pointer and occupancy count. Pointers wrap from FifoDepth−1 to 0.
- InAccept = (count < FifoDepth).
- Push occurs when InValid && InAccept.
- OutSend = (count > 0). OutData shows the oldest entry whenever OutSend=1 (first-word fall-through) and is don't-care when empty.
- Pop occurs when OutReady && OutSend. OutReady while empty is ignored, with no underflow.
- InValid while full is dropped: no write, and state is unchanged.
- Simultaneous push and pop: both occur, count unchanged, FIFO order preserved.
- When full, InAccept stays 0 in that cycle even if a pop occurs (no bypass).
- When empty, a push is not visible on OutData in the same cycle (no fall-through bypass).

## Timing

Reset (Reset=0, asynchronous) values:

- AlarmCount=0, AlarmDone follows AlarmEnable && (0==AlarmThreshold−1).
- CtrCount=CtrInitial.
- FIFO empty: OutSend=0, InAccept=1, pointers 0.

Reset behaviour:

- Deassertion is synchronous-safe: the first active edge after Reset rises may already act on the inputs.
- Reset asserted mid-operation discards FIFO contents immediately.

Latency and throughput:

- All outputs except AlarmDone, InAccept and OutSend are registered.
- Counter updates are visible the cycle after the controlling input.
- Push → OutSend=1 with the data on OutData: 1 cycle.
- Pop → next entry on OutData: 1 cycle.
- FIFO sustains one push and one pop every cycle.

## Test plan

- Reset low then high, AlarmThreshold=2, AlarmEnable=1 for 5 cycles → AlarmCount 0,1,0,1,0; AlarmDone high on the cycles with count=1.
- Reset → CtrCount=12. Then:
  - CtrEnable ×3 → 15;
  - CtrClear with CtrEnable → 0;
  - CtrLoad with CtrIn=31, then CtrEnable → 31, then 0 (wrap);
  - CtrSet together with CtrClear → 12.
- FIFO push A, B (depth 2) → InAccept drops to 0 after B. Push C while full is dropped. Then:
  - pop → OutData=A, then B, then OutSend=0;
  - C never appears.
- Push and pop in the same cycle at count=1 → count stays 1, next head correct. Pop while empty → no change, OutSend stays 0.
- Fill the FIFO, then assert Reset=0 asynchronously between clock edges → OutSend=0 and CtrCount=12 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iv_count_fifo_primitives_if.sv
// iv_count_fifo_primitives_if: valid/ready push and pop handshake of the header FIFO.
interface iv_count_fifo_primitives_if #(
    parameter int FifoWidth = 32
) ();
    logic [FifoWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_accept;
    logic [FifoWidth-1:0] out_data;
    logic                 out_send;
    logic                 out_ready;
    modport master (
        output in_data, in_valid, out_ready,
        input  in_accept, out_data, out_send
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_accept, out_data, out_send
    );
endinterface

// File: rtl/iv_count_fifo_primitives.sv
// iv_count_fifo_primitives: modulo-N turn counter, settable up-counter and a small FWFT FIFO
// sharing one clock and reset.
module iv_count_fifo_primitives #(
    parameter int AlarmThreshold = 2,
    parameter int CtrWidth       = 5,
    parameter int CtrInitial     = 12,
    parameter int FifoWidth      = 32,
    parameter int FifoDepth      = 2,
    localparam int AW = AlarmThreshold > 1 ? $clog2(AlarmThreshold) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alarm_enable,
    output logic [AW-1:0]       alarm_count,
    output logic                alarm_done,
    input  logic                ctr_set,
    input  logic                ctr_clear,
    input  logic                ctr_load,
    input  logic                ctr_enable,
    input  logic [CtrWidth-1:0] ctr_in,
    output logic [CtrWidth-1:0] ctr_count,
    iv_count_fifo_primitives_if.slave fifo
);
    localparam int PW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
    localparam int CW = $clog2(FifoDepth + 1);

    logic [FifoWidth-1:0] mem [FifoDepth];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop;

    assign alarm_done = alarm_enable && alarm_count == AW'(AlarmThreshold - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            alarm_count <= '0;
        else if (alarm_enable)
            alarm_count <= alarm_done ? '0 : alarm_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ctr_count <= CtrWidth'(CtrInitial);
        else
            ctr_count <= ctr_set    ? CtrWidth'(CtrInitial) :
                         ctr_clear  ? '0 :
                         ctr_load   ? ctr_in :
                         ctr_enable ? ctr_count + 1'b1 : ctr_count;

    // Accept is based on the pre-edge count only, so a full FIFO never bypasses a pop.
    assign fifo.in_accept = count < CW'(FifoDepth);
    assign fifo.out_send  = count != '0;
    assign fifo.out_data  = mem[rd_ptr];
    assign push = fifo.in_valid && fifo.in_accept;
    assign pop  = fifo.out_ready && fifo.out_send;

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= fifo.in_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr == PW'(FifoDepth - 1) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr == PW'(FifoDepth - 1) ? '0 : rd_ptr + 1'b1;
            count <= push && !pop ? count + 1'b1 :
                     pop && !push ? count - 1'b1 : count;
        end
endmodule

// File: tb/tb_iv_count_fifo_primitives.sv
// tb_iv_count_fifo_primitives: scoreboard bench with directed test-plan steps and random traffic.
module tb_iv_count_fifo_primitives;
    localparam int T  = 2;
    localparam int CI = 12;
    localparam int D  = 2;

    logic       clk = 0;
    logic       rst_n = 1;
    logic       alarm_enable = 0;
    logic [0:0] alarm_count;
    logic       alarm_done;
    logic       ctr_set = 0, ctr_clear = 0, ctr_load = 0, ctr_enable = 0;
    logic [4:0] ctr_in = 0;
    logic [4:0] ctr_count;

    iv_count_fifo_primitives_if #(.FifoWidth(32)) fi ();

    iv_count_fifo_primitives dut (
        .clk(clk), .rst_n(rst_n),
        .alarm_enable(alarm_enable), .alarm_count(alarm_count), .alarm_done(alarm_done),
        .ctr_set(ctr_set), .ctr_clear(ctr_clear), .ctr_load(ctr_load),
        .ctr_enable(ctr_enable), .ctr_in(ctr_in), .ctr_count(ctr_count),
        .fifo(fi.slave)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    logic [31:0] q[$];
    bit exp_send = 0, exp_acc = 1, run = 0;
    int m_alarm = 0, m_ctr = CI;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Issue one cycle of stimulus; the scoreboard learns what the FIFO should hold.
    task automatic step(input bit av, input bit cs, input bit cc, input bit cl, input bit ce,
                        input logic [4:0] ci, input bit iv, input logic [31:0] id, input bit rd);
        alarm_enable = av; ctr_set = cs; ctr_clear = cc; ctr_load = cl; ctr_enable = ce;
        ctr_in = ci; fi.in_valid = iv; fi.in_data = id; fi.out_ready = rd;
        exp_send = q.size() > 0;
        exp_acc  = q.size() < D;
        if (iv && exp_acc) q.push_back(id);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) if (run) begin
        chk("alarm_count", 32'(alarm_count), 32'(m_alarm));
        chk("alarm_done", 32'(alarm_done), 32'(alarm_enable && m_alarm == T - 1));
        chk("ctr_count", 32'(ctr_count), 32'(m_ctr));
        chk("out_send", 32'(fi.out_send), 32'(exp_send));
        chk("in_accept", 32'(fi.in_accept), 32'(exp_acc));
        if (fi.out_ready && exp_send) chk("out_data", fi.out_data, q.pop_front());
        if (rst_n) begin
            if (alarm_enable) m_alarm = (m_alarm + 1) % T;
            if (ctr_set) m_ctr = CI;
            else if (ctr_clear) m_ctr = 0;
            else if (ctr_load) m_ctr = int'(ctr_in);
            else if (ctr_enable) m_ctr = (m_ctr + 1) % 32;
        end
    end

    initial begin
        fi.in_valid = 0; fi.in_data = 0; fi.out_ready = 0;
        #1 rst_n = 0;
        #2;
        chk("rst_alarm_count", 32'(alarm_count), 0);
        chk("rst_ctr_count", 32'(ctr_count), CI);
        chk("rst_out_send", 32'(fi.out_send), 0);
        chk("rst_in_accept", 32'(fi.in_accept), 1);
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1 run = 1;
        // alarm 0,1,0,1,0 with counter 12 -> 15 then clear-wins-over-enable
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 5'd31, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
        step(0, 1, 1, 1, 1, 5'd7, 0, 0, 0);
        // FIFO: fill, drop when full, drain, pop empty, simultaneous push/pop
        step(0, 0, 0, 0, 0, 0, 1, 32'hA, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hB, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hC, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hC, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'hD, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hE, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 5'($urandom),
                 $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
        step(1, 0, 0, 0, 1, 0, 1, 32'hF0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 32'hF1, 0);
        step(1, 0, 0, 0, 1, 0, 1, 32'hF2, 0);
        // asynchronous reset between edges must clear everything without a clock
        alarm_enable = 0; ctr_set = 0; ctr_clear = 0; ctr_load = 0; ctr_enable = 0;
        fi.in_valid = 0; fi.out_ready = 0;
        rst_n = 0;
        #1;
        chk("async_out_send", 32'(fi.out_send), 0);
        chk("async_in_accept", 32'(fi.in_accept), 1);
        chk("async_ctr_count", 32'(ctr_count), CI);
        chk("async_alarm_count", 32'(alarm_count), 0);
        q.delete(); exp_send = 0; exp_acc = 1; m_ctr = CI; m_alarm = 0;
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1, 0, 1, 32'h55, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
